// File: rtl/vga_pattern_pkg.sv
// Shared encodings and limits for the VGA pattern datapath (scheduler and colour stage).
package vga_pattern_pkg;

  localparam int unsigned H_VISIBLE = 1280;
  localparam int unsigned V_VISIBLE = 960;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned RND_W     = 13;
  localparam int unsigned MODE_W    = 3;
  localparam int unsigned COLOUR_W  = 12;
  localparam int unsigned BEAT_W    = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OR    = 3'd0,
    MODE_XOR   = 3'd1,
    MODE_AND   = 3'd2,
    MODE_NAND  = 3'd3,
    MODE_XNOR  = 3'd4,
    MODE_SPLIT = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    ST_WAIT_BEAT = 2'd0,
    ST_ARMED     = 2'd1,
    ST_COMMIT    = 2'd2
  } sched_state_e;

  typedef struct packed {
    mode_e                mode;
    logic [2:0]           slope;
    logic [5:0]           offset;
    logic [COLOUR_W-1:0]  colour_a;
    logic [COLOUR_W-1:0]  colour_b;
  } pattern_params_t;

  // Sequential mode advance with wrap at num_modes-1.
  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur,
                                                  input int unsigned num_modes);
    return (cur == MODE_W'(num_modes - 1)) ? '0 : MODE_W'(cur + MODE_W'(1));
  endfunction

  // Folds an out-of-range random mode index back into 0..num_modes-1.
  function automatic logic [MODE_W-1:0] fold_mode(input logic [MODE_W-1:0] raw,
                                                  input int unsigned num_modes);
    return (32'(raw) >= num_modes) ? MODE_W'(32'(raw) - num_modes) : raw;
  endfunction

endpackage

// File: rtl/frame_boundary_det.sv
// Detects the first non-visible line start; boundary_c is the raw match, boundary_pulse
// is its one-cycle registered copy.
module frame_boundary_det
  import vga_pattern_pkg::*;
#(
  parameter int unsigned V_MAX = V_VISIBLE
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [CNT_W-1:0] h_count,
  input  logic [CNT_W-1:0] v_count,
  output logic             boundary_c,
  output logic             boundary_pulse
);

  assign boundary_c = (v_count == CNT_W'(V_MAX)) && (h_count == '0);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) boundary_pulse <= 1'b0;
    else        boundary_pulse <= boundary_c;
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Picks pattern mode/colour/geometry on tempo beats and commits them at the frame boundary.
// Optional: define PATTERN_SCHED_RANDOM_MODE_EN to take the next mode from rnd_a[12:10].
module pattern_scheduler
  import vga_pattern_pkg::*;
#(
  parameter int unsigned BEATS_PER_STEP = 4,
  parameter int unsigned NUM_MODES      = 6,
  parameter int unsigned V_PIXEL_MAX    = V_VISIBLE
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                half_sec_pulse,
  input  logic                freeze,
  input  logic [CNT_W-1:0]    h_count,
  input  logic [CNT_W-1:0]    v_count,
  input  logic [RND_W-1:0]    rnd_a,
  input  logic [RND_W-1:0]    rnd_b,
  input  logic [RND_W-1:0]    rnd_c,
  output logic [MODE_W-1:0]   mode,
  output logic [2:0]          slope,
  output logic [5:0]          offset,
  output logic [COLOUR_W-1:0] colour_a,
  output logic [COLOUR_W-1:0] colour_b,
  output logic                param_update
);

  logic            boundary_c;
  logic            boundary_pulse;
  sched_state_e    state;
  logic [BEAT_W-1:0] beat_cnt;
  logic            snap_valid;
  pattern_params_t snap_q;
  pattern_params_t params_q;
  pattern_params_t snap_next_c;
  logic [MODE_W-1:0] mode_next_c;
  logic            unused_rnd_c;

  frame_boundary_det #(
    .V_MAX(V_PIXEL_MAX)
  ) u_boundary_det (
    .clk_in         (clk_in),
    .reset          (reset),
    .h_count        (h_count),
    .v_count        (v_count),
    .boundary_c     (boundary_c),
    .boundary_pulse (boundary_pulse)
  );

`ifdef PATTERN_SCHED_RANDOM_MODE_EN
  assign mode_next_c  = fold_mode(rnd_a[12:10], NUM_MODES);
  assign unused_rnd_c = ^{rnd_a[9], rnd_b[12], rnd_c[12]};
`else
  assign mode_next_c  = next_mode(params_q.mode, NUM_MODES);
  assign unused_rnd_c = ^{rnd_a[12:9], rnd_b[12], rnd_c[12]};
`endif

  // Parameter set sampled in the boundary cycle itself.
  always_comb begin
    snap_next_c          = '0;
    snap_next_c.mode     = mode_e'(mode_next_c);
    snap_next_c.slope    = rnd_a[2:0];
    snap_next_c.offset   = rnd_a[8:3];
    snap_next_c.colour_a = rnd_b[COLOUR_W-1:0];
    snap_next_c.colour_b = rnd_c[COLOUR_W-1:0];
  end

  // snap_valid marks that the boundary behind boundary_pulse was seen while already ARMED,
  // so a boundary coinciding with the arming beat is never committed late.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state        <= ST_WAIT_BEAT;
      beat_cnt     <= '0;
      snap_valid   <= 1'b0;
      snap_q       <= '0;
      params_q     <= '0;
      param_update <= 1'b0;
    end else begin
      param_update <= 1'b0;
      snap_valid   <= (state == ST_ARMED) && boundary_c;
      if ((state == ST_ARMED) && boundary_c) snap_q <= snap_next_c;
      case (state)
        ST_WAIT_BEAT: begin
          if (half_sec_pulse && !freeze) begin
            if (beat_cnt == BEAT_W'(BEATS_PER_STEP - 1)) begin
              state    <= ST_ARMED;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (freeze) begin
            state    <= ST_WAIT_BEAT;
            beat_cnt <= '0;
          end else if (boundary_pulse && snap_valid) begin
            state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state        <= ST_WAIT_BEAT;
          params_q     <= snap_q;
          param_update <= 1'b1;
        end
        default: state <= ST_WAIT_BEAT;
      endcase
    end
  end

  assign mode     = params_q.mode;
  assign slope    = params_q.slope;
  assign offset   = params_q.offset;
  assign colour_a = params_q.colour_a;
  assign colour_b = params_q.colour_b;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler: reset, stepping, coincident beat/boundary, freeze,
// mid-run reset and mode source.
module tb_pattern_scheduler;

`ifdef PATTERN_SCHED_RANDOM_MODE_EN
  localparam bit RANDOM_BUILD = 1'b1;
`else
  localparam bit RANDOM_BUILD = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset;
  logic        half_sec_pulse;
  logic        freeze;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic [12:0] rnd_a;
  logic [12:0] rnd_b;
  logic [12:0] rnd_c;
  logic [2:0]  mode;
  logic [2:0]  slope;
  logic [5:0]  offset;
  logic [11:0] colour_a;
  logic [11:0] colour_b;
  logic        param_update;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  pattern_scheduler dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .half_sec_pulse (half_sec_pulse),
    .freeze         (freeze),
    .h_count        (h_count),
    .v_count        (v_count),
    .rnd_a          (rnd_a),
    .rnd_b          (rnd_b),
    .rnd_c          (rnd_c),
    .mode           (mode),
    .slope          (slope),
    .offset         (offset),
    .colour_a       (colour_a),
    .colour_b       (colour_b),
    .param_update   (param_update)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      half_sec_pulse = 1'b1;
      tick();
      half_sec_pulse = 1'b0;
      tick();
    end
  endtask

  task automatic boundary;
    v_count = 12'd960;
    h_count = 12'd0;
    tick();
    v_count = 12'd100;
    h_count = 12'd100;
  endtask

  // Ticks n cycles, returns index of first param_update and total pulses seen.
  task automatic watch(input int n, output int first, output int cnt);
    first = 0;
    cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (param_update === 1'b1) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; half_sec_pulse = 1'b0; freeze = 1'b0;
    h_count = 12'd100; v_count = 12'd100;
    rnd_a = '0; rnd_b = '0; rnd_c = '0;
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({mode, slope, offset, colour_a, colour_b, param_update} !== 37'd0) begin
      fails++;
      $display("FAIL reset_async: got %h required 0",
               {mode, slope, offset, colour_a, colour_b, param_update});
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    tests++;
    if ({mode, colour_a, colour_b, param_update} !== 28'd0) begin
      fails++;
      $display("FAIL reset_release: got %h required 0", {mode, colour_a, colour_b, param_update});
    end
  endtask

  task automatic test_first_step;
    int first, cnt;
    logic [2:0] exp_mode;
    exp_mode = RANDOM_BUILD ? 3'd2 : 3'd1;
    rnd_a = 13'h0A5F; rnd_b = 13'h0F80; rnd_c = 13'h100F;
    beats(4);
    tests++;
    if (param_update !== 1'b0 || mode !== 3'd0) begin
      fails++;
      $display("FAIL step1_armed_stable: mode %0d pu %b required 0 0", mode, param_update);
    end
    boundary();
    watch(8, first, cnt);
    tests++;
    if (first !== 2 || cnt !== 1) begin
      fails++;
      $display("FAIL step1_latency: first %0d count %0d required 2 1", first, cnt);
    end
    tests++;
    if ({mode, slope, offset, colour_a, colour_b} !== {exp_mode, 3'd7, 6'h0B, 12'hF80, 12'h00F}) begin
      fails++;
      $display("FAIL step1_params: mode %0d slope %0d off %h a %h b %h required %0d 7 0b f80 00f",
               mode, slope, offset, colour_a, colour_b, exp_mode);
    end
  endtask

  task automatic test_sequence;
    int first, cnt;
    logic [2:0] exp_seq [6];
    logic [12:0] a;
    exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    for (int i = 0; i < 6; i++) begin
      a = {exp_seq[i], 10'(i * 37 + 5)};
      rnd_a = a;
      rnd_b = 13'(12'h100 + 12'(i));
      rnd_c = 13'(12'hA00 + 12'(i));
      beats(4);
      boundary();
      watch(8, first, cnt);
      tests++;
      if (first !== 2 || cnt !== 1) begin
        fails++;
        $display("FAIL seq%0d_update: first %0d count %0d required 2 1", i, first, cnt);
      end
      tests++;
      if ({mode, slope, offset, colour_a, colour_b} !==
          {exp_seq[i], a[2:0], a[8:3], 12'(12'h100 + 12'(i)), 12'(12'hA00 + 12'(i))}) begin
        fails++;
        $display("FAIL seq%0d_params: mode %0d slope %0d off %h a %h b %h required mode %0d",
                 i, mode, slope, offset, colour_a, colour_b, exp_seq[i]);
      end
    end
  endtask

  task automatic test_coincident_beat;
    int first, cnt;
    rnd_a = 13'h1FFF; rnd_b = 13'h0111; rnd_c = 13'h0222;
    beats(3);
    half_sec_pulse = 1'b1;
    v_count = 12'd960; h_count = 12'd0;
    tick();
    half_sec_pulse = 1'b0;
    v_count = 12'd100; h_count = 12'd100;
    watch(8, first, cnt);
    tests++;
    if (cnt !== 0 || mode !== 3'd1) begin
      fails++;
      $display("FAIL coincident_no_update: count %0d mode %0d required 0 1", cnt, mode);
    end
    rnd_a = {3'd2, 10'h0C3}; rnd_b = 13'h0ABC; rnd_c = 13'h0DEF;
    boundary();
    watch(8, first, cnt);
    tests++;
    if (first !== 2 || cnt !== 1) begin
      fails++;
      $display("FAIL coincident_next_frame: first %0d count %0d required 2 1", first, cnt);
    end
    tests++;
    if ({mode, slope, offset, colour_a, colour_b} !== {3'd2, 3'd3, 6'h18, 12'hABC, 12'hDEF}) begin
      fails++;
      $display("FAIL coincident_params: mode %0d slope %0d off %h a %h b %h required 2 3 18 abc def",
               mode, slope, offset, colour_a, colour_b);
    end
  endtask

  task automatic test_freeze;
    int first, cnt;
    rnd_a = {3'd3, 10'h155}; rnd_b = 13'h0123; rnd_c = 13'h0456;
    beats(4);
    freeze = 1'b1;
    tick();
    boundary();
    beats(2);
    watch(6, first, cnt);
    tests++;
    if (cnt !== 0 || mode !== 3'd2) begin
      fails++;
      $display("FAIL freeze_cancel: count %0d mode %0d required 0 2", cnt, mode);
    end
    freeze = 1'b0;
    beats(3);
    boundary();
    watch(6, first, cnt);
    tests++;
    if (cnt !== 0) begin
      fails++;
      $display("FAIL freeze_beats_ignored: count %0d required 0", cnt);
    end
    beats(1);
    boundary();
    watch(6, first, cnt);
    tests++;
    if (first !== 2 || cnt !== 1 || mode !== 3'd3 || slope !== 3'd5 || offset !== 6'h2A) begin
      fails++;
      $display("FAIL freeze_resume: first %0d count %0d mode %0d slope %0d off %h required 2 1 3 5 2a",
               first, cnt, mode, slope, offset);
    end
  endtask

  task automatic test_reset_armed;
    int first, cnt;
    rnd_a = {3'd1, 10'h00A}; rnd_b = 13'h0FFF; rnd_c = 13'h0EEE;
    beats(4);
    boundary();
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({mode, slope, offset, colour_a, colour_b, param_update} !== 37'd0) begin
      fails++;
      $display("FAIL reset_armed_async: got %h required 0",
               {mode, slope, offset, colour_a, colour_b, param_update});
    end
    watch(3, first, cnt);
    reset = 1'b1;
    watch(4, first, cnt);
    tests++;
    if (cnt !== 0 || mode !== 3'd0) begin
      fails++;
      $display("FAIL reset_armed_no_update: count %0d mode %0d required 0 0", cnt, mode);
    end
    beats(3);
    boundary();
    watch(6, first, cnt);
    tests++;
    if (cnt !== 0) begin
      fails++;
      $display("FAIL reset_restart_count: count %0d required 0", cnt);
    end
    beats(1);
    boundary();
    watch(6, first, cnt);
    tests++;
    if (first !== 2 || cnt !== 1 || mode !== 3'd1 || slope !== 3'd2 || offset !== 6'h01 ||
        colour_a !== 12'hFFF || colour_b !== 12'hEEE) begin
      fails++;
      $display("FAIL reset_restart_update: first %0d count %0d mode %0d slope %0d off %h a %h b %h",
               first, cnt, mode, slope, offset, colour_a, colour_b);
    end
  endtask

  task automatic test_mode_source;
    int first, cnt;
    logic [2:0] exp_mode [3];
    logic [2:0] src [3];
    src = '{3'd7, 3'd5, 3'd6};
    if (RANDOM_BUILD) exp_mode = '{3'd1, 3'd5, 3'd0};
    else              exp_mode = '{3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 3; i++) begin
      rnd_a = {src[i], 10'h000};
      rnd_b = 13'h0050; rnd_c = 13'h0060;
      beats(4);
      boundary();
      watch(6, first, cnt);
      tests++;
      if (cnt !== 1 || mode !== exp_mode[i]) begin
        fails++;
        $display("FAIL mode_src%0d: count %0d mode %0d required 1 %0d", i, cnt, mode, exp_mode[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_sequence();
    test_coincident_beat();
    test_freeze();
    test_reset_armed();
    test_mode_source();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
